// File: rtl/fp_add_sequencer_pkg.sv
// Shared types and constants for the multi-cycle single-precision adder.
package fp_add_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam int MAN_W    = 24;   // hidden bit + 23 fraction bits
    localparam int GRS_W    = 3;    // guard, round, sticky
    localparam int SUM_W    = 28;   // carry + mantissa + GRS

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } state_t;

endpackage

// File: rtl/fp_add_sequencer_if.sv
// Operand/result handshake bundle for fp_add_sequencer.
//
// Handshake rules (both directions): a transfer happens on a rising edge where
// valid && ready are both high. The source holds valid and its payload stable
// until that transfer; the sink may drive ready independently of valid.
// Upstream: in_valid/x/y from source, in_ready from the adder.
// Downstream: out_valid/result/overflow from the adder, out_ready from consumer.
interface fp_add_sequencer_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;

    // Operand source and result consumer side
    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, result, overflow
    );

    // Adder side
    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, result, overflow
    );

endinterface

// File: rtl/fp_add_sequencer_round.sv
// Round-to-nearest-even on a normalized 27-bit mantissa {1.f, G, R, S},
// plus the exponent bump on mantissa carry and overflow-to-infinity.
module fp_add_round
    import fp_add_pkg::*;
(
    input  logic [MAN_W+GRS_W-1:0] i_man,
    input  logic [7:0]             i_exp,
    input  logic                   i_sign,
    output logic [31:0]            o_result,
    output logic                   o_overflow
);

    logic         w_guard;
    logic         w_round;
    logic         w_sticky;
    logic         w_lsb;
    logic         w_inc;
    logic [MAN_W:0] w_man_rnd;
    logic [8:0]   w_exp_rnd;
    logic [22:0]  w_frac;

    assign w_guard  = i_man[2];
    assign w_round  = i_man[1];
    assign w_sticky = i_man[0];
    assign w_lsb    = i_man[3];
    assign w_inc    = w_guard & (w_round | w_sticky | w_lsb);

    // Increment, renormalize on carry-out, and saturate to infinity at the top exponent
    always_comb begin
        w_man_rnd = {1'b0, i_man[MAN_W+GRS_W-1:GRS_W]} + {{MAN_W{1'b0}}, w_inc};
        w_exp_rnd = {1'b0, i_exp} + {8'd0, w_man_rnd[MAN_W]};
        // A cleared hidden bit means the increment rippled into bit 24,
        // so the mantissa is exactly 1.0 and the fraction is zero.
        w_frac    = w_man_rnd[MAN_W-1] ? w_man_rnd[22:0] : 23'd0;
        o_overflow = (w_exp_rnd >= 9'(EXP_MAX));
        if (o_overflow) begin
            o_result = {i_sign, 8'hFF, 23'd0};
        end else begin
            o_result = {i_sign, w_exp_rnd[7:0], w_frac};
        end
    end

endmodule

// File: rtl/fp_add_sequencer.sv
// Multi-cycle IEEE-754 single-precision adder: compare/swap, one-bit-per-cycle
// alignment, 28-bit add/subtract, one-bit-per-cycle normalization, RNE rounding.
module fp_add_sequencer
    import fp_add_pkg::*;
#(
    parameter int ALIGN_MAX = 27
) (
    input  logic                 clk,
    input  logic                 reset,
    fp_add_sequencer_if.slave    bus,
    output state_t               dbg_state
);

    localparam int          CNT_W     = $clog2(ALIGN_MAX + 1);
    localparam logic [7:0]  ALIGN_CAP = 8'(ALIGN_MAX);
    localparam logic [7:0]  EXP_ONES  = 8'(EXP_MAX);
    localparam int          MG_W      = MAN_W + GRS_W;

    state_t             r_state;
    logic [MG_W-1:0]    r_big;
    logic [MG_W-1:0]    r_small;
    logic [SUM_W-1:0]   r_sum;
    logic [7:0]         r_exp;
    logic               r_sign;
    logic               r_sub;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_result;
    logic               r_overflow;
    logic               r_out_valid;

    logic [7:0]         w_x_exp;
    logic [7:0]         w_y_exp;
    logic               w_x_zero;
    logic               w_y_zero;
    logic               w_any_nan;
    logic               w_x_big;
    logic [31:0]        w_big_op;
    logic [31:0]        w_small_op;
    logic [7:0]         w_diff;
    logic [CNT_W-1:0]   w_cnt;
    logic [SUM_W-1:0]   w_add;
    logic [31:0]        w_rnd_result;
    logic               w_rnd_ovf;

    assign w_x_exp   = bus.x[30:23];
    assign w_y_exp   = bus.y[30:23];
    // Denormals are flushed: any zero exponent counts as zero
    assign w_x_zero  = (w_x_exp == 8'd0);
    assign w_y_zero  = (w_y_exp == 8'd0);
    assign w_any_nan = (w_x_exp == EXP_ONES) || (w_y_exp == EXP_ONES);
    assign w_x_big   = (bus.x[30:0] >= bus.y[30:0]);
    assign w_big_op   = w_x_big ? bus.x : bus.y;
    assign w_small_op = w_x_big ? bus.y : bus.x;
    assign w_diff    = w_big_op[30:23] - w_small_op[30:23];
    // Past the cap every further shift would only feed sticky, which is already set
    assign w_cnt     = (w_diff > ALIGN_CAP) ? ALIGN_CAP[CNT_W-1:0] : w_diff[CNT_W-1:0];

    // Big magnitude is always >= aligned small, so subtraction never goes negative
    assign w_add = r_sub ? ({1'b0, r_big} - {1'b0, r_small})
                         : ({1'b0, r_big} + {1'b0, r_small});

    fp_add_round u_round (
        .i_man      (r_sum[MG_W-1:0]),
        .i_exp      (r_exp),
        .i_sign     (r_sign),
        .o_result   (w_rnd_result),
        .o_overflow (w_rnd_ovf)
    );

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.overflow  = r_overflow;
    assign dbg_state     = r_state;

    // Sequencer FSM with its datapath registers and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_big       <= '0;
            r_small     <= '0;
            r_sum       <= '0;
            r_exp       <= '0;
            r_sign      <= 1'b0;
            r_sub       <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (w_any_nan) begin
                            r_result    <= QNAN;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else if (w_x_zero && w_y_zero) begin
                            r_result    <= {bus.x[31] & bus.y[31], 31'd0};
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else if (w_x_zero) begin
                            r_result    <= bus.y;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else if (w_y_zero) begin
                            r_result    <= bus.x;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_big   <= {1'b1, w_big_op[22:0], 3'b000};
                            r_small <= {1'b1, w_small_op[22:0], 3'b000};
                            r_exp   <= w_big_op[30:23];
                            r_sign  <= w_big_op[31];
                            r_sub   <= w_big_op[31] ^ w_small_op[31];
                            r_cnt   <= w_cnt;
                            r_state <= ST_ALIGN;
                        end
                    end
                end
                ST_ALIGN: begin
                    if (r_cnt != '0) begin
                        r_small <= {1'b0, r_small[MG_W-1:2], r_small[1] | r_small[0]};
                        r_cnt   <= r_cnt - CNT_W'(1);
                    end else begin
                        r_state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    r_sum   <= w_add;
                    r_state <= ST_NORM;
                end
                ST_NORM: begin
                    if (r_sum == '0) begin
                        r_result    <= 32'd0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (r_sum[SUM_W-1]) begin
                        r_sum   <= {1'b0, r_sum[SUM_W-1:2], r_sum[1] | r_sum[0]};
                        r_exp   <= r_exp + 8'd1;
                        r_state <= ST_ROUND;
                    end else if (r_sum[SUM_W-2]) begin
                        r_state <= ST_ROUND;
                    end else if (r_exp == 8'd1) begin
                        // Would go subnormal: flush to zero, keeping the sign
                        r_result    <= {r_sign, 31'd0};
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_sum <= {r_sum[SUM_W-2:0], 1'b0};
                        r_exp <= r_exp - 8'd1;
                    end
                end
                ST_ROUND: begin
                    r_result    <= w_rnd_result;
                    r_overflow  <= w_rnd_ovf;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fp_add_sequencer.md
# fp_add_sequencer

Multi-cycle sequencer for the single-precision floating-point adder datapath: exponent compare/swap, iterative alignment shift, 28-bit mantissa add/subtract, iterative normalization, round-to-nearest-even, and overflow detection. It sits between an upstream operand source and a downstream result consumer, with a valid/ready handshake on each side, and processes one addition at a time. Shifts advance one bit per cycle, so latency depends on the operands.

## Interface
- ALIGN_MAX, 27: cap on alignment shift count; further shifting contributes only sticky.
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  operands x, y valid
- in_ready  output  1  high only in IDLE
- x  input  32  IEEE-754 single operand
- y  input  32  IEEE-754 single operand
- out_valid  output  1  result valid, held until accepted
- out_ready  input  1  consumer accepts result
- result  output  32  sum x+y
- overflow  output  1  result exponent reached 255, valid with out_valid

## Operation
- States: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
- **IDLE.** Accept on in_valid&&in_ready.
  - Exp==0 inputs are treated as zero (denormals flushed).
  - Special cases go directly to DONE:
    - Either exp==255 → 0x7FC00000.
    - Both zero → 0x80000000 if both signs are 1, else 0x00000000.
    - Exactly one zero → the other operand unchanged.
  - Otherwise, swap so big = larger {exp, frac}. Load 27-bit mantissas {hidden 1, frac[22:0], G=0, R=0, S=0}. cnt = min(exp_big-exp_small, ALIGN_MAX). Go to ALIGN.
- **ALIGN.** If cnt!=0: shift small right 1, OR the bit shifted out into S (bit0), cnt--. If cnt==0 at entry: go to ADD.
- **ADD.** One cycle.
  - Signs equal: 28-bit sum = big + small.
  - Signs differ: big - small.
  - Sign = sign of big. exp = exp_big.
- **NORM**, one check per cycle:
  - sum==0 → result 0x00000000, go to DONE.
  - bit27 set → shift right 1 with sticky, exp+1, go to ROUND.
  - bit26 set → go to ROUND.
  - Else, if exp==1 → result ±0 (sign kept), go to DONE.
  - Else → shift left 1, exp-1, stay in NORM.
- **ROUND** (RNE on bits [2:0]): increment mantissa if G && (R||S||LSB), where LSB is bit3.
  - Carry out of the 24-bit mantissa → exp+1, mantissa = 1.0.
  - exp>=255 → result {sign, 0xFF, 0}, overflow=1.
  - Go to DONE.
- **DONE.** out_valid=1; result and overflow held stable. On out_ready go to IDLE, clearing out_valid and overflow.
- No new operand is accepted while busy; in_ready=0 outside IDLE.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, overflow=0; working registers 0.
- Reset asserted mid-operation: the operation is abandoned, with no output. Recovery is in IDLE on the first edge after deassertion.
- Accept at edge 0. Normal path: out_valid rises after edge 5 + min(diff, ALIGN_MAX) + L, where L = number of left shifts.
  - Carry-normalize adds no extra cycles.
  - Zero-sum path: out_valid after edge 4.
  - Special cases: out_valid after edge 1.
- out_ready held high in DONE: out_valid is high for exactly one cycle and in_ready returns the next cycle. There is no same-cycle turnaround.
- out_ready low: out_valid, result and overflow are held indefinitely.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Structure
- Package fp_add_pkg:
  - State enum.
  - Constants EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, MAN_W=24, GRS_W=3, SUM_W=28.
- Sub-module fp_add_round: combinational RNE plus exponent-increment/overflow. Inputs: 27-bit mantissa, 8-bit exp, sign. Outputs: 32-bit result, overflow. Instantiated once in the ROUND path.
- The FSM, alignment counter and shift registers stay in fp_add_sequencer.

## Test plan
- 0x3F800000 + 0x3F800000 (1+1) → 0x40000000, overflow=0, out_valid after edge 5.
- 0x3F800000 + 0xBF400000 (1-0.75) → 0x3E800000, diff=1, L=2, out_valid after edge 8.
- 0x3F800000 + 0x33800000 (1+2^-24, exact tie) → 0x3F800000 (ties to even), out_valid after edge 29.
- 0x3F800000 + 0xBF800000 → 0x00000000 after edge 4. 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000 with overflow=1.
- Backpressure: out_ready=0 for 10 cycles in DONE → result, out_valid and overflow stable, in_ready=0 and a new in_valid ignored. Release → one handshake, IDLE next cycle.
- Reset pulse during ALIGN of 0x3F800000 + 0x33800000 → out_valid never asserts. After release, in_ready=1, and 1+1 then yields 0x40000000 normally.
